// File: rtl/frame_measure_if.sv
// Bus between the acquisition sequencer tap and the frame measurement engine.
// Carries frame control and samples in, and the published per-frame results out.
interface frame_measure_if;
    logic               frame_start;
    logic               frame_end;
    logic               sample_valid;
    logic [27:0]        sample;
    logic signed [13:0] cross_level;

    logic               busy;
    logic               meas_valid;
    logic signed [13:0] ch1_min;
    logic signed [13:0] ch1_max;
    logic signed [13:0] ch2_min;
    logic signed [13:0] ch2_max;
    logic signed [22:0] ch1_sum;
    logic signed [22:0] ch2_sum;
    logic [8:0]         sample_cnt;
    logic [8:0]         cross_cnt;
    logic [8:0]         first_cross;
    logic [8:0]         last_cross;

    modport master (
        output frame_start, frame_end, sample_valid, sample, cross_level,
        input  busy, meas_valid, ch1_min, ch1_max, ch2_min, ch2_max,
               ch1_sum, ch2_sum, sample_cnt, cross_cnt, first_cross, last_cross
    );

    modport slave (
        input  frame_start, frame_end, sample_valid, sample, cross_level,
        output busy, meas_valid, ch1_min, ch1_max, ch2_min, ch2_max,
               ch1_sum, ch2_sum, sample_cnt, cross_cnt, first_cross, last_cross
    );
endinterface

// File: rtl/frame_measure.sv
// Per-frame min/max/sum on both channels plus ch1 rising-crossing statistics,
// accumulated from the display-memory write stream and published once per frame.
module frame_measure #(
    parameter int FRAME_LEN = 500,
    parameter int HYST      = 16
) (
    input  logic           clk,
    input  logic           reset,
    frame_measure_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, PUBLISH} state_t;

    state_t             state;
    logic signed [13:0] min1, max1, min2, max2;
    logic signed [22:0] sum1, sum2;
    logic [8:0]         cnt, xcnt, first, last;
    logic               armed;

    logic signed [13:0] ch1, ch2;
    logic signed [14:0] arm_level;
    logic               arm_hit, cross_hit, last_sample, restart;

    assign ch1 = bus.sample[13:0];
    assign ch2 = bus.sample[27:14];
    // 15-bit so a level near -8192 does not wrap positive after subtracting HYST
    assign arm_level   = $signed({bus.cross_level[13], bus.cross_level}) - 15'(HYST);
    assign arm_hit     = $signed({ch1[13], ch1}) <= arm_level;
    assign cross_hit   = armed && (ch1 >= bus.cross_level);
    assign last_sample = (cnt == 9'(FRAME_LEN - 1));
    assign restart     = bus.frame_start && (state != PUBLISH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            min1            <= '0;
            max1            <= '0;
            min2            <= '0;
            max2            <= '0;
            sum1            <= '0;
            sum2            <= '0;
            cnt             <= '0;
            xcnt            <= '0;
            first           <= '0;
            last            <= '0;
            armed           <= 1'b0;
            bus.busy        <= 1'b0;
            bus.meas_valid  <= 1'b0;
            bus.ch1_min     <= '0;
            bus.ch1_max     <= '0;
            bus.ch2_min     <= '0;
            bus.ch2_max     <= '0;
            bus.ch1_sum     <= '0;
            bus.ch2_sum     <= '0;
            bus.sample_cnt  <= '0;
            bus.cross_cnt   <= '0;
            bus.first_cross <= '0;
            bus.last_cross  <= '0;
        end else begin
            bus.meas_valid <= 1'b0;
            // busy lags the state by one cycle so it drops together with meas_valid
            bus.busy       <= (state != IDLE);

            unique case (state)
                IDLE:    if (bus.frame_start) state <= ACCUM;
                ACCUM:   if (!bus.frame_start &&
                             (bus.frame_end || (bus.sample_valid && last_sample)))
                             state <= PUBLISH;
                PUBLISH: begin
                    bus.ch1_min     <= (cnt == '0) ? '0 : min1;
                    bus.ch1_max     <= (cnt == '0) ? '0 : max1;
                    bus.ch2_min     <= (cnt == '0) ? '0 : min2;
                    bus.ch2_max     <= (cnt == '0) ? '0 : max2;
                    bus.ch1_sum     <= sum1;
                    bus.ch2_sum     <= sum2;
                    bus.sample_cnt  <= cnt;
                    bus.cross_cnt   <= xcnt;
                    bus.first_cross <= first;
                    bus.last_cross  <= last;
                    bus.meas_valid  <= 1'b1;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (restart) begin
                min1  <= 14'sd8191;
                max1  <= -14'sd8192;
                min2  <= 14'sd8191;
                max2  <= -14'sd8192;
                sum1  <= '0;
                sum2  <= '0;
                cnt   <= '0;
                xcnt  <= '0;
                first <= '0;
                last  <= '0;
                armed <= 1'b0;
            end else if (state == ACCUM && bus.sample_valid) begin
                cnt <= cnt + 9'd1;
                if (ch1 < min1) min1 <= ch1;
                if (ch1 > max1) max1 <= ch1;
                if (ch2 < min2) min2 <= ch2;
                if (ch2 > max2) max2 <= ch2;
                sum1 <= sum1 + 23'(ch1);
                sum2 <= sum2 + 23'(ch2);
                // counting disarms, so one sample never both arms and counts
                if (cross_hit) begin
                    xcnt  <= xcnt + 9'd1;
                    if (xcnt == '0) first <= cnt;
                    last  <= cnt;
                    armed <= 1'b0;
                end else if (arm_hit) begin
                    armed <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_frame_measure.sv
// Directed bench for frame_measure: expected results are modelled per frame,
// queued when the frame is driven, and checked when meas_valid pulses.
module tb_frame_measure;
    localparam int FRAME_LEN = 500;
    localparam int HYST      = 16;

    typedef struct {
        int mn1, mx1, mn2, mx2, s1, s2, cnt, xc, fx, lx;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   mv_cnt   = 0;
    exp_t sb[$];
    exp_t e;
    logic [27:0] q[$];

    frame_measure_if bus();

    frame_measure #(.FRAME_LEN(FRAME_LEN), .HYST(HYST)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #10 clk = ~clk;

    function automatic void chk(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endfunction

    function automatic exp_t model(input logic [27:0] s[$], input int lvl);
        exp_t r;
        int n, c1, c2;
        bit arm;
        logic signed [13:0] t1, t2;
        r = '{default: 0};
        r.mn1 = 8191; r.mx1 = -8192; r.mn2 = 8191; r.mx2 = -8192;
        arm = 1'b0;
        n = (s.size() < FRAME_LEN) ? s.size() : FRAME_LEN;
        r.cnt = n;
        for (int i = 0; i < n; i++) begin
            t1 = s[i][13:0];
            t2 = s[i][27:14];
            c1 = t1;
            c2 = t2;
            if (c1 < r.mn1) r.mn1 = c1;
            if (c1 > r.mx1) r.mx1 = c1;
            if (c2 < r.mn2) r.mn2 = c2;
            if (c2 > r.mx2) r.mx2 = c2;
            r.s1 += c1;
            r.s2 += c2;
            if (arm && c1 >= lvl) begin
                if (r.xc == 0) r.fx = i;
                r.lx = i;
                r.xc++;
                arm = 1'b0;
            end else if (c1 <= lvl - HYST) begin
                arm = 1'b1;
            end
        end
        if (n == 0) begin
            r.mn1 = 0; r.mx1 = 0; r.mn2 = 0; r.mx2 = 0;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (bus.meas_valid) begin
            mv_cnt++;
            chk("publish_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("ch1_min", bus.ch1_min, e.mn1);
                chk("ch1_max", bus.ch1_max, e.mx1);
                chk("ch2_min", bus.ch2_min, e.mn2);
                chk("ch2_max", bus.ch2_max, e.mx2);
                chk("ch1_sum", bus.ch1_sum, e.s1);
                chk("ch2_sum", bus.ch2_sum, e.s2);
                chk("sample_cnt", bus.sample_cnt, e.cnt);
                chk("cross_cnt", bus.cross_cnt, e.xc);
                chk("first_cross", bus.first_cross, e.fx);
                chk("last_cross", bus.last_cross, e.lx);
            end
        end
    end

    task automatic run_frame(input logic [27:0] s[$], input int lvl, input bit coincide);
        sb.push_back(model(s, lvl));
        bus.cross_level = 14'(lvl);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        if (s.size() == 0) @(negedge clk);
        for (int i = 0; i < int'(s.size()); i++) begin
            bus.sample_valid = 1'b1;
            bus.sample       = s[i];
            bus.frame_end    = coincide && (i == int'(s.size()) - 1);
            @(negedge clk);
            if (i == 1) chk("busy_accum", bus.busy, 1);
        end
        bus.sample_valid = 1'b0;
        bus.frame_end    = 1'b0;
        if (!coincide && s.size() < FRAME_LEN) begin
            bus.frame_end = 1'b1;
            @(negedge clk);
            bus.frame_end = 1'b0;
        end
        if (s.size() <= FRAME_LEN) begin
            chk("mv_at_E", bus.meas_valid, 0);
            chk("busy_at_E", bus.busy, 1);
            @(negedge clk);
            chk("mv_at_E1", bus.meas_valid, 1);
            @(negedge clk);
            chk("mv_at_E2", bus.meas_valid, 0);
            chk("busy_at_E2", bus.busy, 0);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        reset            = 1'b1;
        bus.frame_start  = 1'b0;
        bus.frame_end    = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        bus.cross_level  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mv", bus.meas_valid, 0);
        chk("rst_ch1_min", bus.ch1_min, 0);
        chk("rst_sample_cnt", bus.sample_cnt, 0);
        reset = 1'b0;
        @(negedge clk);

        // ramp, auto-close at FRAME_LEN
        q.delete();
        for (int i = 0; i < 500; i++) q.push_back({14'(i - 250), 14'(i - 250)});
        run_frame(q, 0, 1'b0);

        // square wave on ch1
        q.delete();
        for (int i = 0; i < 100; i++)
            q.push_back({14'(i * 3), ((i / 10) % 2 == 0) ? -14'sd100 : 14'sd100});
        run_frame(q, 0, 1'b0);

        // noise that never arms; frame_end with the last sample
        q.delete();
        for (int i = 0; i < 50; i++) q.push_back({14'(-i), (i % 2 == 0) ? 14'd0 : 14'd8});
        run_frame(q, 4, 1'b1);

        // empty frame
        q.delete();
        base = mv_cnt;
        run_frame(q, 0, 1'b0);
        chk("empty_pulses", mv_cnt - base, 1);

        // extremes, over-length frame
        q.delete();
        for (int i = 0; i < 256; i++) q.push_back({14'(i), 14'sd8191});
        for (int i = 0; i < 256; i++) q.push_back({-14'sd8192, -14'sd8192});
        run_frame(q, 0, 1'b0);
        repeat (5) @(negedge clk);

        // restart: frame_start with frame_end discards the first part
        base = mv_cnt;
        q.delete();
        for (int i = 0; i < 6; i++) q.push_back({14'(i + 1), 14'(-20 + 10 * i)});
        sb.push_back(model(q, 0));
        bus.cross_level = '0;
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.sample_valid = 1'b1;
            bus.sample       = {14'sd4000, 14'sd4000};
            @(negedge clk);
        end
        bus.sample_valid = 1'b0;
        bus.frame_start  = 1'b1;
        bus.frame_end    = 1'b1;
        @(negedge clk);
        bus.frame_start  = 1'b0;
        bus.frame_end    = 1'b0;
        chk("restart_no_publish", mv_cnt - base, 0);
        for (int i = 0; i < 6; i++) begin
            bus.sample_valid = 1'b1;
            bus.sample       = q[i];
            @(negedge clk);
        end
        bus.sample_valid = 1'b0;
        bus.frame_end    = 1'b1;
        @(negedge clk);
        bus.frame_end    = 1'b0;
        repeat (4) @(negedge clk);
        chk("restart_pulses", mv_cnt - base, 1);

        // reset mid-frame: no publish, outputs cleared
        base = mv_cnt;
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.sample_valid = 1'b1;
            bus.sample       = {14'(i), 14'(i)};
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset            = 1'b0;
        bus.sample_valid = 1'b0;
        chk("rstmid_busy", bus.busy, 0);
        chk("rstmid_ch1_sum", bus.ch1_sum, 0);
        chk("rstmid_sample_cnt", bus.sample_cnt, 0);
        chk("rstmid_cross_cnt", bus.cross_cnt, 0);
        repeat (6) @(negedge clk);
        chk("rstmid_no_publish", mv_cnt - base, 0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
